pipelined_barrel_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath.
- Replaces the fixed 16-bit, one-hot-select shifter with a binary shift amount (0..WIDTH-1) and five operating modes.
- Adds a valid/ready handshake with full back-pressure and a configurable pipeline depth.
- Sits between the packet-processing ALU stage and the output register file.

---
 rtl/shifter_pkg.sv | 37 +++
 rtl/shift_level.sv | 48 ++++
 rtl/pipelined_barrel_shifter.sv | 132 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types and helpers for the pipelined barrel shifter:
//               operation encoding, legality test and the mapping of mux
//               levels onto pipeline register stages.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        LSL = 3'd0,
        LSR = 3'd1,
        ASR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } mode_e;

    // Encodings 5..7 are reserved and flagged as errors at the output.
    function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
        return (mode <= 3'd4);
    endfunction

    // One past the last mux level held by register stage k (1-based).
    function automatic int stage_bound(input int k, input int sh_w, input int lat);
        return (k * sh_w + lat - 1) / lat;
    endfunction

    // Register stage feeding mux level lvl; 0 means the raw input port.
    function automatic int level_src(input int lvl, input int sh_w, input int lat);
        return (lvl * lat) / sh_w;
    endfunction

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
// Module      : shift_level
// Description : One combinational level of the log2 shifter. Shifts by
//               2**LEVEL when enabled, in the direction and with the fill
//               (zero, sign or wrapped bits) that the operation requires.
//               Illegal operations pass data through untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_en,
    input  logic [MODE_W-1:0] i_mode,
    output logic [WIDTH-1:0]  o_data
);

    localparam int c_S = 2 ** LEVEL;

    logic [c_S-1:0] w_fill_l;
    logic [c_S-1:0] w_fill_r;

    // Pick fill bits, then apply a fixed-distance left or right shift.
    always_comb begin
        w_fill_l = '0;
        w_fill_r = '0;
        o_data   = i_data;
        case (i_mode)
            ROL:     w_fill_l = i_data[WIDTH-1 -: c_S];
            ROR:     w_fill_r = i_data[c_S-1:0];
            ASR:     w_fill_r = {c_S{i_data[WIDTH-1]}};
            default: ;
        endcase
        if (i_en) begin
            case (i_mode)
                LSL, ROL:      o_data = {i_data[WIDTH-1-c_S:0], w_fill_l};
                LSR, ASR, ROR: o_data = {w_fill_r, i_data[WIDTH-1:c_S]};
                default:       o_data = i_data;
            endcase
        end
    end

endmodule : shift_level
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Parametrised barrel shifter (LSL/LSR/ASR/ROL/ROR) built from
//               SH_W mux levels split over LAT register stages, with a
//               valid/ready handshake and a single global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SH_W  = $clog2(WIDTH),
    parameter int LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SH_W-1:0]   in_sh,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_zero,
    output logic              out_err
);

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 4");
    end
    if (SH_W != $clog2(WIDTH)) begin : g_bad_shw
        $error("pipelined_barrel_shifter: SH_W must equal clog2(WIDTH)");
    end
    if ((LAT < 1) || (LAT > SH_W)) begin : g_bad_lat
        $error("pipelined_barrel_shifter: LAT must lie in 1..SH_W");
    end

    // Stage sources: index 0 is the input port, index k the register stage k.
    logic              w_sv    [0:LAT-1];
    logic [WIDTH-1:0]  w_sd    [0:LAT-1];
    logic [SH_W-1:0]   w_ssh   [0:LAT-1];
    logic [MODE_W-1:0] w_smode [0:LAT-1];
    logic              w_adv;

    // Whole pipe moves when the output slot is empty or being drained.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv && !rst;

    assign w_sv[0]    = in_valid;
    assign w_sd[0]    = in_data;
    assign w_ssh[0]   = in_sh;
    assign w_smode[0] = in_mode;

    // Mux levels; the first level of each stage reads that stage's register.
    for (genvar l = 0; l < SH_W; l++) begin : g_level
        localparam int c_SRC   = level_src(l, SH_W, LAT);
        localparam bit c_FIRST = (l == 0) || (level_src(l - 1, SH_W, LAT) != c_SRC);
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;

        if (c_FIRST) begin : g_from_reg
            assign w_in = w_sd[c_SRC];
        end else begin : g_from_level
            assign w_in = g_level[l-1].w_out;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .LEVEL (l)
        ) u_level (
            .i_data (w_in),
            .i_en   (w_ssh[c_SRC][l]),
            .i_mode (w_smode[c_SRC]),
            .o_data (w_out)
        );
    end

    // Register stages; mode and amount travel alongside the data.
    for (genvar k = 1; k <= LAT; k++) begin : g_stage
        localparam int c_LAST_LVL = stage_bound(k, SH_W, LAT) - 1;
        logic              r_valid;
        logic [WIDTH-1:0]  r_data;
        logic [MODE_W-1:0] r_mode;
        logic [WIDTH-1:0]  w_cap;

        if (k == LAT) begin : g_cap_last
            assign w_cap = is_legal_mode(w_smode[k-1]) ? g_level[c_LAST_LVL].w_out : '0;
        end else begin : g_cap_mid
            assign w_cap = g_level[c_LAST_LVL].w_out;
        end

        // Stage register: cleared on reset, loaded on global advance.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_mode  <= '0;
            end else if (w_adv) begin
                r_valid <= w_sv[k-1];
                r_data  <= w_cap;
                r_mode  <= w_smode[k-1];
            end
        end

        if (k < LAT) begin : g_fwd
            logic [SH_W-1:0] r_sh;

            // Shift amount is only needed by later stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sh <= '0;
                end else if (w_adv) begin
                    r_sh <= w_ssh[k-1];
                end
            end

            assign w_sv[k]    = r_valid;
            assign w_sd[k]    = r_data;
            assign w_ssh[k]   = r_sh;
            assign w_smode[k] = r_mode;
        end else begin : g_out
            assign out_valid = r_valid;
            assign out_data  = r_data;
            assign out_zero  = r_valid && (r_data == '0);
            assign out_err   = r_valid && !is_legal_mode(r_mode);
        end
    end

endmodule : pipelined_barrel_shifter
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Directed self-checking bench: 16-bit LAT=2 instance for the
//               handshake, latency, stall and reset behaviour, plus 32-bit
//               instances (LAT 1/2/4) swept against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_sh = '0;
    logic [2:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_err;

    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic [4:0]  s_sh = '0;
    logic [2:0]  s_mode = '0;
    logic        s_ready = 1'b1;
    logic        s_rdy1, s_rdy2, s_rdy4;
    logic        o1_valid, o2_valid, o4_valid;
    logic [31:0] o1_data, o2_data, o4_data;
    logic        o1_zero, o2_zero, o4_zero;
    logic        o1_err, o2_err, o4_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(16), .LAT(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sh(in_sh), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_err(out_err));

    pipelined_barrel_shifter #(.WIDTH(32), .LAT(1)) u_w32_l1 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_rdy1),
        .in_data(s_data), .in_sh(s_sh), .in_mode(s_mode),
        .out_valid(o1_valid), .out_ready(s_ready), .out_data(o1_data),
        .out_zero(o1_zero), .out_err(o1_err));

    pipelined_barrel_shifter #(.WIDTH(32), .LAT(2)) u_w32_l2 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_rdy2),
        .in_data(s_data), .in_sh(s_sh), .in_mode(s_mode),
        .out_valid(o2_valid), .out_ready(s_ready), .out_data(o2_data),
        .out_zero(o2_zero), .out_err(o2_err));

    pipelined_barrel_shifter #(.WIDTH(32), .LAT(4)) u_w32_l4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(s_rdy4),
        .in_data(s_data), .in_sh(s_sh), .in_mode(s_mode),
        .out_valid(o4_valid), .out_ready(s_ready), .out_data(o4_data),
        .out_zero(o4_zero), .out_err(o4_err));

    // Directed stream table: operand, amount, mode, hand-computed result.
    logic [15:0] t_d   [8] = '{16'h0003, 16'hF000, 16'hF000, 16'h1234,
                               16'h1234, 16'hABCD, 16'h00FF, 16'h8000};
    logic [3:0]  t_n   [8] = '{4'd1, 4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd8, 4'd15};
    logic [2:0]  t_m   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd4, 3'd1};
    logic [15:0] t_exp [8] = '{16'h0006, 16'h0F00, 16'hFF00, 16'h2341,
                               16'h4123, 16'hABCD, 16'hFF00, 16'h0001};

    logic        mon_en = 1'b0;
    logic        sw_en = 1'b0;
    logic [15:0] q16 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];
    logic [32:0] q4 [$];
    logic [31:0] sw_exp [$];
    logic        sw_experr [$];

    always @(negedge clk) if (mon_en && out_valid && out_ready) q16.push_back(out_data);
    always @(negedge clk) if (sw_en && o1_valid) q1.push_back({o1_err, o1_data});
    always @(negedge clk) if (sw_en && o2_valid) q2.push_back({o2_err, o2_data});
    always @(negedge clk) if (sw_en && o4_valid) q4.push_back({o4_err, o4_data});

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input int m);
        logic [63:0] t;
        case (m)
            0: return d << n;
            1: return d >> n;
            2: return 32'($signed(d) >>> n);
            3: begin t = {d, d} << n; return t[63:32]; end
            4: begin t = {d, d} >> n; return t[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    task automatic send_one(input string tag, input logic [15:0] d, input logic [3:0] n,
                            input logic [2:0] m, input logic [15:0] exp_d,
                            input logic exp_err, input logic exp_zero);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_sh = n; in_mode = m;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        check({tag, "_zero"}, 32'(out_zero), 32'(exp_zero));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        int sent;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_zero", 32'(out_zero), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 32'(in_ready), 32'd1);

        // Single beats with exact latency
        send_one("lsl", 16'h00F1, 4'd3, 3'd0, 16'h0788, 1'b0, 1'b0);
        send_one("asr", 16'h8010, 4'd4, 3'd2, 16'hF801, 1'b0, 1'b0);
        send_one("lsr", 16'h8010, 4'd4, 3'd1, 16'h0801, 1'b0, 1'b0);
        send_one("ror", 16'h0001, 4'd1, 3'd4, 16'h8000, 1'b0, 1'b0);
        send_one("rol", 16'h8001, 4'd15, 3'd3, 16'hC000, 1'b0, 1'b0);
        send_one("ill", 16'hFFFF, 4'd0, 3'd6, 16'h0000, 1'b1, 1'b1);
        send_one("after_ill", 16'h0001, 4'd15, 3'd0, 16'h8000, 1'b0, 1'b0);
        send_one("zero_res", 16'h0010, 4'd5, 3'd1, 16'h0000, 1'b0, 1'b1);

        // Back-to-back stream, results on consecutive cycles
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c >= 2) begin
                check("strA_valid", 32'(out_valid), 32'd1);
                check("strA_data", 32'(out_data), 32'(t_exp[c-2]));
            end
            if (c < 8) begin
                in_valid = 1'b1; in_data = t_d[c]; in_sh = t_n[c]; in_mode = t_m[c];
                check("strA_rdy", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("strA_drained", 32'(out_valid), 32'd0);

        // Stream with a three-cycle downstream stall
        mon_en = 1'b1;
        sent = 0;
        held = '0;
        for (int c = 0; c < 40 && q16.size() < 8; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 4 && c <= 6);
            in_valid = (sent < 8);
            if (sent < 8) begin
                in_data = t_d[sent]; in_sh = t_n[sent]; in_mode = t_m[sent];
            end
            @(negedge clk);
            if (c >= 4 && c <= 6) begin
                check("stall_rdy", 32'(in_ready), 32'd0);
                check("stall_valid", 32'(out_valid), 32'd1);
                if (c == 4) held = out_data;
                else check("stall_stable", 32'(out_data), 32'(held));
            end
            if (in_valid && in_ready) sent++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; mon_en = 1'b0;
        check("strB_count", 32'(q16.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < q16.size()) check("strB_data", 32'(q16[i]), 32'(t_exp[i]));

        // Reset with two beats in flight
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 16'h0101; in_sh = 4'd1; in_mode = 3'd0;
        @(posedge clk); #1;
        in_data = 16'h0202;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rdy", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        // 32-bit sweep over all amounts and modes for LAT 1, 2 and 4
        check("sweep_rdy", 32'(s_rdy1 & s_rdy2 & s_rdy4), 32'd1);
        sw_en = 1'b1;
        for (int m = 0; m < 7; m++) begin
            for (int n = 0; n < 32; n++) begin
                if (m < 5 || n == 0) begin
                    @(posedge clk); #1;
                    s_valid = 1'b1;
                    s_data = $urandom;
                    s_sh = 5'(n);
                    s_mode = 3'(m);
                    sw_exp.push_back(ref_shift(s_data, n, m));
                    sw_experr.push_back(m >= 5);
                end
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        sw_en = 1'b0;
        check("sweep_l1_count", 32'(q1.size()), 32'(sw_exp.size()));
        check("sweep_l2_count", 32'(q2.size()), 32'(sw_exp.size()));
        check("sweep_l4_count", 32'(q4.size()), 32'(sw_exp.size()));
        for (int i = 0; i < sw_exp.size(); i++) begin
            if (i < q1.size()) begin
                check("sweep_l1_data", q1[i][31:0], sw_exp[i]);
                check("sweep_l1_err", 32'(q1[i][32]), 32'(sw_experr[i]));
            end
            if (i < q2.size()) begin
                check("sweep_l2_data", q2[i][31:0], sw_exp[i]);
                check("sweep_l2_err", 32'(q2[i][32]), 32'(sw_experr[i]));
            end
            if (i < q4.size()) begin
                check("sweep_l4_data", q4[i][31:0], sw_exp[i]);
                check("sweep_l4_err", 32'(q4[i][32]), 32'(sw_experr[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipelined_barrel_shifter
`default_nettype wire
